// File: rtl/bram_port_arbiter_if.sv
// Client-side bundle for bram_port_arbiter: requests, write data, grants and read return.
interface bram_port_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DATA = 72,
   parameter int ADDR = 10
);
   logic [NREQ-1:0]      req;
   logic [NREQ-1:0]      wr;
   logic [NREQ*ADDR-1:0] addr;
   logic [NREQ*DATA-1:0] din;
   logic [NREQ-1:0]      gnt;
   logic [NREQ-1:0]      rvalid;
   logic [DATA-1:0]      rdata;

   modport master (output req, wr, addr, din, input gnt, rvalid, rdata);
   modport slave  (input req, wr, addr, din, output gnt, rvalid, rdata);
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NREQ clients; zero-fills the RAM after reset.
// Optional BRAM_ARB_LOCK_EN adds a per-requester lock input that holds the grant.
module bram_port_arbiter #(
   parameter int NREQ = 4,
   parameter int DATA = 72,
   parameter int ADDR = 10
) (
   input  logic                clk,
   input  logic                rst,
   bram_port_arbiter_if.slave  cl,
`ifdef BRAM_ARB_LOCK_EN
   input  logic [NREQ-1:0]     lock,
`endif
   output logic                busy,
   output logic                mem_wr,
   output logic [ADDR-1:0]     mem_addr,
   output logic [DATA-1:0]     mem_din,
   input  logic [DATA-1:0]     mem_dout
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [ADDR-1:0] init_addr_q, init_addr_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] rvalid_q, rvalid_d;
   logic [NREQ-1:0] gnt_s;
   logic [PW:0]     cand_s;
   logic            rr_hit_s;
   logic [PW-1:0]   rr_sel_s;
   logic            hold_s;
   logic            hit_s;
   logic [PW-1:0]   sel_s;
`ifdef BRAM_ARB_LOCK_EN
   logic            lock_act_q, lock_act_d;
   logic [PW-1:0]   lock_idx_q, lock_idx_d;
`endif

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
      if (v == PW'(NREQ-1)) begin
         return '0;
      end else begin
         return v + PW'(1);
      end
   endfunction

   assign cl.gnt    = gnt_s;
   assign cl.rvalid = rvalid_q;
   assign cl.rdata  = mem_dout;

   // Round-robin scan from ptr upward, plus the lock override that pins the last grant.
   always_comb begin
      rr_hit_s = 1'b0;
      rr_sel_s = '0;
      cand_s   = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand_s = {1'b0, ptr_q} + (PW+1)'(k);
         if (cand_s >= (PW+1)'(NREQ)) begin
            cand_s = cand_s - (PW+1)'(NREQ);
         end else begin
            cand_s = cand_s;
         end
         if (!rr_hit_s && cl.req[cand_s[PW-1:0]]) begin
            rr_hit_s = 1'b1;
            rr_sel_s = cand_s[PW-1:0];
         end else begin
            rr_hit_s = rr_hit_s;
         end
      end
`ifdef BRAM_ARB_LOCK_EN
      hold_s = lock_act_q && cl.req[lock_idx_q] && lock[lock_idx_q];
      if (hold_s) begin
         sel_s = lock_idx_q;
      end else begin
         sel_s = rr_sel_s;
      end
`else
      hold_s = 1'b0;
      sel_s  = rr_sel_s;
`endif
      hit_s = hold_s || rr_hit_s;
   end

   // Next-state and RAM port drive for the INIT sweep and RUN service.
   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      ptr_d       = ptr_q;
      rvalid_d    = '0;
      gnt_s       = '0;
      busy        = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_din     = '0;
`ifdef BRAM_ARB_LOCK_EN
      lock_act_d  = 1'b0;
      lock_idx_d  = lock_idx_q;
`endif
      case (state_q)
         ST_INIT: begin
            busy        = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = init_addr_q;
            init_addr_d = init_addr_q + ADDR'(1);
            if (init_addr_q == {ADDR{1'b1}}) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_INIT;
            end
         end
         ST_RUN: begin
            if (hit_s) begin
               gnt_s[sel_s]    = 1'b1;
               mem_wr          = cl.wr[sel_s];
               mem_addr        = cl.addr[sel_s*ADDR +: ADDR];
               mem_din         = cl.din[sel_s*DATA +: DATA];
               rvalid_d[sel_s] = ~cl.wr[sel_s];
               // A held lock keeps ptr at (owner+1) so release resumes after the owner.
               if (hold_s) begin
                  ptr_d = ptr_q;
               end else begin
                  ptr_d = wrap_inc(sel_s);
               end
`ifdef BRAM_ARB_LOCK_EN
               lock_act_d = lock[sel_s];
               lock_idx_d = sel_s;
`endif
            end else begin
               ptr_d = ptr_q;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_INIT;
         init_addr_q <= '0;
         ptr_q       <= '0;
         rvalid_q    <= '0;
`ifdef BRAM_ARB_LOCK_EN
         lock_act_q  <= 1'b0;
         lock_idx_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         ptr_q       <= ptr_d;
         rvalid_q    <= rvalid_d;
`ifdef BRAM_ARB_LOCK_EN
         lock_act_q  <= lock_act_d;
         lock_idx_q  <= lock_idx_d;
`endif
      end
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: vector table, hand sequences and random traffic against a behavioural model.
module tb_bram_port_arbiter;
   localparam int NREQ  = 4;
   localparam int DATA  = 72;
   localparam int ADDR  = 4;
   localparam int DEPTH = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            scramble = 1'b0;
   logic            busy;
   logic            mem_wr;
   logic [ADDR-1:0] mem_addr;
   logic [DATA-1:0] mem_din;
   logic [DATA-1:0] mem_dout;
   logic [NREQ-1:0] lock_v;
   logic [DATA-1:0] ram [DEPTH];

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   bit              m_init;
   int              m_cnt;
   int              m_ptr;
   bit              m_locked;
   int              m_li;
   logic [NREQ-1:0] m_pend;
   logic [DATA-1:0] m_pdata;
   logic [DATA-1:0] m_mem [DEPTH];

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  wr;
      logic [3:0]  a;
      logic [71:0] d;
      logic [3:0]  eg;
      logic [3:0]  erv;
      logic [71:0] erd;
   } vec_t;
   vec_t tbl [14];

   bram_port_arbiter_if #(.NREQ(NREQ), .DATA(DATA), .ADDR(ADDR)) bif ();

   bram_port_arbiter #(.NREQ(NREQ), .DATA(DATA), .ADDR(ADDR)) dut (
      .clk      (clk),
      .rst      (rst),
      .cl       (bif.slave),
`ifdef BRAM_ARB_LOCK_EN
      .lock     (lock_v),
`endif
      .busy     (busy),
      .mem_wr   (mem_wr),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   always #5 clk = ~clk;

   // Write-first single-port RAM with 1-cycle read latency; scramble fills it with junk.
   always @(posedge clk) begin
      if (scramble) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= {8'hA5, $urandom, $urandom};
         mem_dout <= '1;
      end else if (mem_wr) begin
         ram[mem_addr] <= mem_din;
         mem_dout      <= mem_din;
      end else begin
         mem_dout <= ram[mem_addr];
      end
   end

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_init   = 1'b1;
      m_cnt    = 0;
      m_ptr    = 0;
      m_locked = 1'b0;
      m_li     = 0;
      m_pend   = '0;
      m_pdata  = '0;
   endtask

   // Drive one cycle of inputs, compare mid-cycle against the model, then advance the model.
   task automatic apply(input logic r, input logic [3:0] rq, input logic [3:0] wv,
                        input logic [15:0] av, input logic [287:0] dv, input logic [3:0] lk);
      int          g;
      bit          hold;
      logic [3:0]  eg;
      logic        ew;
      logic [3:0]  ea;
      logic [71:0] ed;
      logic        eb;
      rst = r; bif.req = rq; bif.wr = wv; bif.addr = av; bif.din = dv; lock_v = lk;
      #4;
      g = -1; hold = 1'b0; eg = '0; ew = 1'b0; ea = '0; ed = '0; eb = 1'b0;
      if (m_init) begin
         ew = 1'b1; ea = 4'(m_cnt); eb = 1'b1;
      end else begin
         if (m_locked && rq[m_li] && lk[m_li]) begin
            g = m_li; hold = 1'b1;
         end else begin
            for (int k = 0; k < NREQ; k++)
               if (g < 0 && rq[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
         end
         if (g >= 0) begin
            eg[g] = 1'b1; ew = wv[g]; ea = av[g*ADDR +: ADDR]; ed = dv[g*DATA +: DATA];
         end
      end
      chk("gnt",      72'(bif.gnt),    72'(eg));
      chk("busy",     72'(busy),       72'(eb));
      chk("mem_wr",   72'(mem_wr),     72'(ew));
      chk("mem_addr", 72'(mem_addr),   72'(ea));
      chk("mem_din",  mem_din,         ed);
      chk("rvalid",   72'(bif.rvalid), 72'(m_pend));
      if (m_pend != '0) chk("rdata", bif.rdata, m_pdata);
      if (r) begin
         model_reset();
      end else if (m_init) begin
         m_mem[m_cnt] = '0;
         m_cnt++;
         if (m_cnt == DEPTH) m_init = 1'b0;
         m_pend = '0;
      end else begin
         m_pend = '0;
         if (g >= 0) begin
            if (wv[g]) m_mem[ea] = ed;
            else begin
               m_pend[g] = 1'b1;
               m_pdata   = m_mem[ea];
            end
            if (!hold) m_ptr = (g + 1) % NREQ;
            m_locked = lk[g];
            m_li     = g;
         end else begin
            m_locked = 1'b0;
         end
      end
   endtask

   task automatic rand_cycle();
      logic [287:0] dv;
      logic [3:0]   lk;
      for (int j = 0; j < 9; j++) dv[j*32 +: 32] = $urandom;
      lk = 4'b0000;
`ifdef BRAM_ARB_LOCK_EN
      if ($urandom_range(0, 3) == 0) lk = 4'($urandom);
`endif
      apply(1'b0, 4'($urandom), 4'($urandom), 16'($urandom), dv, lk);
   endtask

   initial begin
      bif.req = '0; bif.wr = '0; bif.addr = '0; bif.din = '0; lock_v = '0;

      tbl[0]  = '{4'b0001, 4'b0001, 4'd5, 72'hABC, 4'b0001, 4'b0000, 72'h0};
      tbl[1]  = '{4'b0001, 4'b0000, 4'd5, 72'h0,   4'b0001, 4'b0000, 72'h0};
      tbl[2]  = '{4'b0010, 4'b0000, 4'd9, 72'h0,   4'b0010, 4'b0001, 72'hABC};
      tbl[3]  = '{4'b1000, 4'b0000, 4'd9, 72'h0,   4'b1000, 4'b0010, 72'h0};
      tbl[4]  = '{4'b0000, 4'b0000, 4'd0, 72'h0,   4'b0000, 4'b1000, 72'h0};
      for (int i = 0; i < 8; i++)
         tbl[5+i] = '{4'b1111, 4'b0000, 4'd5, 72'h0, 4'(1 << (i % 4)),
                      (i == 0) ? 4'b0000 : 4'(1 << ((i - 1) % 4)), 72'hABC};
      tbl[13] = '{4'b0000, 4'b0000, 4'd0, 72'h0,   4'b0000, 4'b1000, 72'hABC};

      rst = 1'b1; scramble = 1'b1;
      step();
      scramble = 1'b0;
      step();
      model_reset();

      // INIT sweep after reset; requests must be ignored.
      for (int i = 0; i < DEPTH; i++) begin
         apply(1'b0, 4'($urandom), 4'($urandom), 16'($urandom), '0, 4'b0000);
         step();
      end

      for (int i = 0; i < 14; i++) begin
         apply(1'b0, tbl[i].req, tbl[i].wr, {4{tbl[i].a}}, {4{tbl[i].d}}, 4'b0000);
         chk("tbl_gnt",    72'(bif.gnt),    72'(tbl[i].eg));
         chk("tbl_rvalid", 72'(bif.rvalid), 72'(tbl[i].erv));
         if (tbl[i].erv != 4'b0000) chk("tbl_rdata", bif.rdata, tbl[i].erd);
         step();
      end

`ifdef BRAM_ARB_LOCK_EN
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, 4'b0011, 4'b0000, {4{4'd1}}, '0, (i < 3) ? 4'b0001 : 4'b0000);
         chk("lock_gnt", 72'(bif.gnt), (i < 3) ? 72'h1 : 72'h2);
         step();
      end
`endif

      for (int i = 0; i < 300; i++) begin
         rand_cycle();
         step();
      end

      // Reset lands on the cycle requester 2 is granted a read.
      apply(1'b1, 4'b0100, 4'b0000, {4{4'd3}}, '0, 4'b0000);
      chk("rst_gnt", 72'(bif.gnt), 72'h4);
      step();
      apply(1'b0, 4'b0100, 4'b0000, {4{4'd3}}, '0, 4'b0000);
      chk("rst_busy",     72'(busy),       72'h1);
      chk("rst_rvalid",   72'(bif.rvalid), 72'h0);
      chk("rst_mem_addr", 72'(mem_addr),   72'h0);
      step();
      for (int i = 1; i < DEPTH; i++) begin
         apply(1'b0, 4'($urandom), 4'b0000, 16'($urandom), '0, 4'b0000);
         step();
      end
      for (int i = 0; i < 60; i++) begin
         rand_cycle();
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
